// File: rtl/music_pkg.sv
// Shared note codes, ROM entry width and the code-to-one-hot mapping for the melody player.
package music_pkg;

    localparam int ENTRY_W = 7;

    localparam logic [2:0] NOTE_REST = 3'd0;
    localparam logic [2:0] NOTE_DO   = 3'd1;
    localparam logic [2:0] NOTE_RE   = 3'd2;
    localparam logic [2:0] NOTE_MI   = 3'd3;
    localparam logic [2:0] NOTE_FA   = 3'd4;
    localparam logic [2:0] NOTE_SOL  = 3'd5;
    localparam logic [2:0] NOTE_LA   = 3'd6;
    localparam logic [2:0] NOTE_SI   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

    function automatic logic [6:0] note_onehot(input logic [2:0] code);
        if (code == NOTE_REST) begin
            return 7'd0;
        end
        return 7'(7'd1 << (code - 3'd1));
    endfunction

endpackage

// File: rtl/melody_rom.sv
// Note ROM with one-cycle registered read; entries are {dur[3:0], code[2:0]}.
module melody_rom
    import music_pkg::*;
#(
    parameter int LEN    = 32,
    parameter int ADDR_W = 5
) (
    input  logic                clk,
    input  logic [ADDR_W-1:0]   addr,
    output logic [ENTRY_W-1:0]  data
);

    logic [ENTRY_W-1:0] table_rom [LEN];

    // Scale do..si, one rest, then the end marker; everything after reads as end.
    function automatic logic [ENTRY_W-1:0] default_entry(input int idx);
        if (idx <= 6) begin
            return {4'd2, 3'(idx + 1)};
        end
        if (idx == 7) begin
            return {4'd2, NOTE_REST};
        end
        return '0;
    endfunction

    generate
        for (genvar gi = 0; gi < LEN; gi++) begin : g_rom
            assign table_rom[gi] = default_entry(gi);
        end
    endgenerate

    always_ff @(posedge clk) begin
        data <= table_rom[addr];
    end

endmodule

// File: rtl/melody_sequencer.sv
// Steps through melody_rom and drives the tone generator's onoff/note.
// Build option: define MELODY_GAP_EN for a silent last tick on notes with dur >= 2.
module melody_sequencer
    import music_pkg::*;
#(
    parameter int TICK_DIV = 3125000,
    parameter int LEN      = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    output logic              onoff,
    output logic [6:0]        note,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] step
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]     PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LEN - 1);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [PW-1:0]       pre_reg, pre_next;
    logic [3:0]          tick_reg, tick_next;
    logic [2:0]          code_reg, code_next;
    logic [3:0]          dur_reg, dur_next;
    logic                wrap_reg, wrap_next;
    logic                onoff_reg, onoff_next;
    logic [6:0]          note_reg, note_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic [ENTRY_W-1:0]  rom_data;
    logic                end_of_song;
    logic                gap;

    // The ROM is addressed with the next address so its data is ready during LOAD.
    melody_rom #(
        .LEN    (LEN),
        .ADDR_W (ADDR_W)
    ) u_rom (
        .clk  (clk),
        .addr (addr_next),
        .data (rom_data)
    );

    assign end_of_song = (rom_data[6:3] == 4'd0) || wrap_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            pre_reg   <= '0;
            tick_reg  <= '0;
            code_reg  <= '0;
            dur_reg   <= '0;
            wrap_reg  <= 1'b0;
            onoff_reg <= 1'b0;
            note_reg  <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            pre_reg   <= pre_next;
            tick_reg  <= tick_next;
            code_reg  <= code_next;
            dur_reg   <= dur_next;
            wrap_reg  <= wrap_next;
            onoff_reg <= onoff_next;
            note_reg  <= note_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        pre_next   = pre_reg;
        tick_next  = tick_reg;
        code_next  = code_reg;
        dur_next   = dur_reg;
        wrap_next  = wrap_reg;
        if (stop) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_next = ST_LOAD;
                        addr_next  = '0;
                        wrap_next  = 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (end_of_song) begin
                        wrap_next = 1'b0;
                        if (loop) begin
                            state_next = ST_LOAD;
                            addr_next  = '0;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        state_next = ST_PLAY;
                        code_next  = rom_data[2:0];
                        dur_next   = rom_data[6:3];
                        pre_next   = '0;
                        tick_next  = '0;
                    end
                end
                ST_PLAY: begin
                    if (pre_reg == PRE_LAST) begin
                        pre_next  = '0;
                        tick_next = tick_reg + 4'd1;
                        if (tick_reg + 4'd1 == dur_reg) begin
                            state_next = ST_LOAD;
                            // Running off the last address is treated as end of song.
                            if (addr_reg == ADDR_LAST) begin
                                addr_next = '0;
                                wrap_next = 1'b1;
                            end else begin
                                addr_next = addr_reg + 1'b1;
                            end
                        end
                    end else begin
                        pre_next = pre_reg + 1'b1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
`ifdef MELODY_GAP_EN
        gap = (dur_next >= 4'd2) && (tick_next == dur_next - 4'd1);
`else
        gap = 1'b0;
`endif
        busy_next  = (state_next != ST_IDLE);
        note_next  = (state_next == ST_PLAY) ? note_onehot(code_next) : 7'd0;
        onoff_next = (state_next == ST_PLAY) && (code_next != NOTE_REST) && !gap;
        done_next  = (state_reg == ST_LOAD) && !stop && end_of_song && !loop;
    end

    assign onoff = onoff_reg;
    assign note  = note_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;
    assign step  = addr_reg;

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Plays a fixed melody on the seven-tone square-wave generator. It steps through a small note ROM and drives the generator's `onoff` and one-hot `note` inputs, holding each note for a programmed number of beat ticks. It sits between the board's start/stop buttons and the tone generator, and owns all note timing.

## Interface

**Parameters**
- `TICK_DIV`, default 3125000: clk cycles per beat tick (1/8 s at 25 MHz).
- `LEN`, default 32: ROM depth in entries.
- `ADDR_W`, default 5: ROM address width; `2**ADDR_W >= LEN`.

**Ports**
- `clk`  in  1: system clock (25 MHz).
- `rst`  in  1: reset. One clock; reset is synchronous and active-high.
- `start`  in  1: level; begins playback from address 0 when idle.
- `stop`  in  1: level; aborts playback.
- `loop`  in  1: sampled at end of song; 1 restarts at address 0.
- `onoff`  out  1: tone enable to the generator.
- `note`  out  7: one-hot note to the generator; bit0 = do … bit6 = si.
- `busy`  out  1: high in any state other than IDLE.
- `done`  out  1: one-cycle pulse when the song ends without looping.
- `step`  out  ADDR_W: address of the entry currently playing.

## Operation

**ROM entry** (7 bits) = {dur[3:0], code[2:0]}.
- `code` 0 is a rest (`onoff` = 0, `note` = 0). Codes 1–7 map to do…si, i.e. `note = 1 << (code-1)`.
- `dur` is the note length in ticks, 1–15.
- `dur` = 0 is the end-of-song marker.

**States**
- IDLE: `start` & !`stop` → LOAD, with addr = 0.
- LOAD (1 cycle): the ROM is registered, so its output is valid at the end of this cycle.
  - End condition: `dur` = 0 or addr = LEN-1 has already been played.
  - At end of song: if `loop`=1 → LOAD with addr = 0; otherwise → IDLE and `done` pulses.
  - Not at end: latch code/dur, clear the prescaler and tick counter → PLAY.
- PLAY:
  - The prescaler counts 0..TICK_DIV-1. At wrap, the tick counter increments.
  - When tick count = dur → LOAD with addr+1. The addr+1 wraps modulo LEN; a wrap is treated as end of song.

**Stop and start**
- `stop` in any state → IDLE next cycle; `onoff` = 0 and `note` = 0 on that same next cycle.
- `stop` wins over a simultaneous `start`.
- `start` while busy is ignored. Playback restarts only after passing through IDLE.

**Outputs**
- Outputs are registered.
- In PLAY, `note` and `onoff` reflect the latched code.
- In LOAD and IDLE, `note` and `onoff` are 0.
- Counter widths: prescaler `$clog2(TICK_DIV)` bits; tick counter 4 bits.

## Timing

- Reset values: state IDLE, `onoff` 0, `note` 0, `busy` 0, `done` 0, `step` 0, all counters 0.
- Latency from `start` high in IDLE:
  - cycle +1: LOAD, `busy` = 1.
  - cycle +2: PLAY, with `onoff` and `note` valid.
- Note duration: each entry occupies exactly 1 + dur·TICK_DIV cycles. The sound lasts dur·TICK_DIV cycles, followed by a 1-cycle silent LOAD.
- `step` updates on entry to LOAD.
- `done` is high only for the single cycle after the final LOAD.
- `rst` mid-song: same as the reset values on the next edge.

## Configuration

`MELODY_GAP_EN`:
- **Defined:** for entries with dur ≥ 2, `onoff` is forced to 0 during the last tick (the final TICK_DIV cycles) of PLAY, giving staccato articulation so repeated notes are audible. `note` is unchanged. Entries with dur = 1 have no gap.
- **Undefined:** `onoff` is high for the whole PLAY state of any non-rest entry.

## Structure

**Package `music_pkg`**
- Note code localparams: `NOTE_REST`, `NOTE_DO` … `NOTE_SI`.
- Entry width constant (7).
- Function `note_onehot(code)` → 7-bit one-hot.

**Sub-module `melody_rom`**
- Parameters `LEN`, `ADDR_W`.
- Registered read: `addr` → `data`, 1-cycle latency.
- Default contents:
  - Addresses 0–6: do…si, each with dur = 2.
  - Address 7: rest, dur = 2.
  - Address 8: end marker.
  - Remaining addresses: 0.

## Test plan

Bench uses TICK_DIV = 4.

1. Reset then idle:
   - `rst` for 2 cycles, `start` = 0 → all outputs 0 for 50 cycles.
2. Single pass, `loop` = 0, gap off:
   - `start` pulse → `note` = 0000001 at cycle +2 for 8 cycles.
   - Then 1 cycle of 0, then 0000010, and so on through si.
   - Rest entry: 8 cycles with `onoff` = 0.
   - `done` pulses exactly once, 74 cycles after start (8 entries × 9 cycles + 2 LOAD cycles).
3. Loop:
   - `loop` = 1 → after the rest entry, `step` returns to 0 and do replays.
   - `done` never pulses.
   - Set `loop` = 0 mid-song → song ends on the next pass.
4. Stop mid-note:
   - `stop` during mi PLAY → next cycle `onoff` = 0, `note` = 0, `busy` = 0.
   - `start` and `stop` asserted together in IDLE → stays IDLE.
5. Start while busy and reset mid-song:
   - `start` re-asserted during fa → no restart; `step` keeps advancing.
   - `rst` during sol → next cycle all outputs are at their reset values.
6. `MELODY_GAP_EN` defined:
   - Each dur = 2 note shows `onoff` = 1 for 4 cycles, then 0 for 4 cycles.
   - `note` is held through the gap.
